// File: rtl/bus_decoder.sv
// bus_decoder: single-master address decoder with per-region wait states.
// A strobe seen in IDLE either opens an ACCESS to the lowest-index region
// containing the address, or goes straight to DONE as a bus error when the
// address is unmapped or both strobes are low at once.
// Optional feature macro: BUS_DECODER_ERR_CAPTURE_EN adds a register that
// holds the address of the first error access on err_address.
module bus_decoder #(
  parameter int                            NUM_REGIONS  = 2,
  parameter logic [16*NUM_REGIONS-1:0]     REGION_BASE  = {16'hFF80, 16'h0000},
  parameter logic [16*NUM_REGIONS-1:0]     REGION_LIMIT = {16'hFFFE, 16'h3FFF},
  parameter logic [4*NUM_REGIONS-1:0]      REGION_WAIT  = {4'd0, 4'd2}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [15:0]                db_address,
  input  logic                       db_nread,
  input  logic                       db_nwrite,
  input  logic [7:0]                 db_wdata,
  output logic [7:0]                 db_rdata,
  output logic                       db_ready,
  output logic [15:0]                tgt_address,
  output logic [7:0]                 tgt_wdata,
  output logic                       tgt_nread,
  output logic                       tgt_nwrite,
  output logic [NUM_REGIONS-1:0]     tgt_nsel,
  input  logic [8*NUM_REGIONS-1:0]   tgt_rdata,
  output logic                       bus_error,
  output logic [15:0]                err_address
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [NUM_REGIONS-1:0] NSEL_OFF = {NUM_REGIONS{1'b1}};

  state_e                   state_q, state_d;
  logic [15:0]              addr_q, addr_d;
  logic                     nread_q, nread_d;
  logic                     nwrite_q, nwrite_d;
  logic [2:0]               region_q, region_d;
  logic [3:0]               wait_q, wait_d;
  logic [NUM_REGIONS-1:0]   nsel_q, nsel_d;
  logic [7:0]               rdata_q, rdata_d;
  logic                     ready_q, ready_d;
  logic                     err_q, err_d;

  logic                     hit_s;
  logic [2:0]               hit_idx_s;
  logic [3:0]               hit_wait_s;
  logic [NUM_REGIONS-1:0]   onecold_s;
  logic [7:0]               rd_sel_s;
  logic                     any_s;
  logic                     both_s;
  logic                     err_set_s;

  assign any_s     = ~db_nread | ~db_nwrite;
  assign both_s    = ~db_nread & ~db_nwrite;
  assign tgt_wdata = db_wdata;

  // Region decode; scanning high to low lets the lowest matching index win.
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = 3'd0;
    hit_wait_s = 4'd0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((db_address >= REGION_BASE[16*i +: 16]) && (db_address <= REGION_LIMIT[16*i +: 16])) begin
        hit_s      = 1'b1;
        hit_idx_s  = 3'(i);
        hit_wait_s = REGION_WAIT[4*i +: 4];
      end else begin
        hit_s      = hit_s;
        hit_idx_s  = hit_idx_s;
        hit_wait_s = hit_wait_s;
      end
    end
  end

  // One-cold select pattern for the decoded region.
  always_comb begin
    onecold_s = NSEL_OFF;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      onecold_s[i] = (hit_idx_s != 3'(i));
    end
  end

  // Read-data mux for the region currently being accessed.
  always_comb begin
    rd_sel_s = 8'hFF;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (region_q == 3'(i)) begin
        rd_sel_s = tgt_rdata[8*i +: 8];
      end else begin
        rd_sel_s = rd_sel_s;
      end
    end
  end

  // Next-state and output logic of the access FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    nread_d   = nread_q;
    nwrite_d  = nwrite_q;
    region_d  = region_q;
    wait_d    = wait_q;
    nsel_d    = nsel_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_set_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          addr_d = db_address;
          if (hit_s && !both_s) begin
            state_d  = ACCESS;
            nread_d  = db_nread;
            nwrite_d = db_nwrite;
            region_d = hit_idx_s;
            wait_d   = hit_wait_s;
            nsel_d   = onecold_s;
          end else begin
            state_d   = DONE;
            rdata_d   = 8'hFF;
            err_set_s = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!any_s) begin
          // Master gave up: drop the select without completing.
          state_d  = IDLE;
          nsel_d   = NSEL_OFF;
          nread_d  = 1'b1;
          nwrite_d = 1'b1;
        end else if (wait_q == 4'd0) begin
          state_d  = DONE;
          nsel_d   = NSEL_OFF;
          nread_d  = 1'b1;
          nwrite_d = 1'b1;
          if (!nread_q) begin
            rdata_d = rd_sel_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      DONE: begin
        ready_d = any_s;
        if (any_s) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        nsel_d  = NSEL_OFF;
      end
    endcase
    err_d = err_q | err_set_s;
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= 16'h0000;
      nread_q  <= 1'b1;
      nwrite_q <= 1'b1;
      region_q <= 3'd0;
      wait_q   <= 4'd0;
      nsel_q   <= NSEL_OFF;
      rdata_q  <= 8'hFF;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      nread_q  <= nread_d;
      nwrite_q <= nwrite_d;
      region_q <= region_d;
      wait_q   <= wait_d;
      nsel_q   <= nsel_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign db_rdata    = rdata_q;
  assign db_ready    = ready_q;
  assign tgt_address = addr_q;
  assign tgt_nread   = nread_q;
  assign tgt_nwrite  = nwrite_q;
  assign tgt_nsel    = nsel_q;
  assign bus_error   = err_q;

`ifdef BUS_DECODER_ERR_CAPTURE_EN
  logic [15:0] err_addr_q, err_addr_d;

  // Keep the address of the first error only; later errors are ignored.
  always_comb begin
    if (err_set_s && !err_q) begin
      err_addr_d = db_address;
    end else begin
      err_addr_d = err_addr_q;
    end
  end

  // Error address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr_q <= 16'h0000;
    end else begin
      err_addr_q <= err_addr_d;
    end
  end

  assign err_address = err_addr_q;
`else
  assign err_address = 16'h0000;
`endif

endmodule

// File: tb/tb_bus_decoder.sv
// Directed, table-driven bench for bus_decoder (default 2-region map).
module tb_bus_decoder;

`ifdef BUS_DECODER_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] db_address = 16'h0000;
  logic        db_nread = 1'b1;
  logic        db_nwrite = 1'b1;
  logic [7:0]  db_wdata = 8'h00;
  logic [7:0]  db_rdata;
  logic        db_ready;
  logic [15:0] tgt_address;
  logic [7:0]  tgt_wdata;
  logic        tgt_nread;
  logic        tgt_nwrite;
  logic [1:0]  tgt_nsel;
  logic [15:0] tgt_rdata = 16'h0000;
  logic        bus_error;
  logic [15:0] err_address;

  int n_checks = 0;
  int n_fail   = 0;

  bus_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .db_address  (db_address),
    .db_nread    (db_nread),
    .db_nwrite   (db_nwrite),
    .db_wdata    (db_wdata),
    .db_rdata    (db_rdata),
    .db_ready    (db_ready),
    .tgt_address (tgt_address),
    .tgt_wdata   (tgt_wdata),
    .tgt_nread   (tgt_nread),
    .tgt_nwrite  (tgt_nwrite),
    .tgt_nsel    (tgt_nsel),
    .tgt_rdata   (tgt_rdata),
    .bus_error   (bus_error),
    .err_address (err_address)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        nread;
    logic        nwrite;
    logic [7:0]  wdata;
    logic [15:0] trd;
    logic [1:0]  exp_nsel;
    int          exp_low;
    int          exp_lat;
    logic [7:0]  exp_rdata;
    logic        exp_err;
    logic [15:0] exp_ea;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [15:0] a, input logic nr, input logic nw,
                              input logic [7:0] wd, input logic [15:0] trd,
                              input logic [1:0] ns, input int low, input int lat,
                              input logic [7:0] rd, input logic er, input logic [15:0] ea);
    vec_t v;
    v.addr = a; v.nread = nr; v.nwrite = nw; v.wdata = wd; v.trd = trd;
    v.exp_nsel = ns; v.exp_low = low; v.exp_lat = lat;
    v.exp_rdata = rd; v.exp_err = er; v.exp_ea = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    db_nread  = 1'b1;
    db_nwrite = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one full access; caller is at a negedge. Sample index j is the
  // state just after edge k+j, where edge k first sees the strobe.
  task automatic apply(input vec_t v, input int id);
    int lat;
    int low;
    int bad;
    lat = -1; low = 0; bad = 0;
    tgt_rdata  = v.trd;
    db_address = v.addr;
    db_wdata   = v.wdata;
    db_nread   = v.nread;
    db_nwrite  = v.nwrite;
    for (int j = 0; j < 12 && lat < 0; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 0) begin
        db_address = ~v.addr;
        if (v.exp_low > 0) begin
          chk($sformatf("v%0d tgt_address", id), tgt_address, v.addr);
          chk($sformatf("v%0d tgt_nread", id), tgt_nread, v.nread);
          chk($sformatf("v%0d tgt_nwrite", id), tgt_nwrite, v.nwrite);
          chk($sformatf("v%0d tgt_wdata", id), tgt_wdata, v.wdata);
        end
      end
      if (v.exp_low > 0 && tgt_nsel == v.exp_nsel) low++;
      else if (tgt_nsel != 2'b11) bad++;
      if (db_ready) lat = j;
    end
    chk($sformatf("v%0d ready_latency", id), lat, v.exp_lat);
    chk($sformatf("v%0d nsel_low_cycles", id), low, v.exp_low);
    chk($sformatf("v%0d nsel_wrong", id), bad, 0);
    chk($sformatf("v%0d db_rdata", id), db_rdata, v.exp_rdata);
    chk($sformatf("v%0d bus_error", id), bus_error, v.exp_err);
    chk($sformatf("v%0d err_address", id), err_address, v.exp_ea);
    for (int h = 0; h < 2; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d hold_ready", id), db_ready, 1'b1);
      chk($sformatf("v%0d hold_rdata", id), db_rdata, v.exp_rdata);
    end
    db_nread  = 1'b1;
    db_nwrite = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d ready_release", id), db_ready, 1'b0);
    chk($sformatf("v%0d nsel_release", id), tgt_nsel, 2'b11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_cnt;
    vecs[0] = mk(16'h0123, 1'b0, 1'b1, 8'h00, {8'h5A, 8'hA5}, 2'b10, 3, 4, 8'hA5, 1'b0, 16'h0000);
    vecs[1] = mk(16'hFF90, 1'b1, 1'b0, 8'h3C, {8'h5A, 8'hA5}, 2'b01, 1, 2, 8'hA5, 1'b0, 16'h0000);
    vecs[2] = mk(16'h3FFF, 1'b0, 1'b1, 8'h00, {8'h11, 8'h77}, 2'b10, 3, 4, 8'h77, 1'b0, 16'h0000);
    vecs[3] = mk(16'hFF80, 1'b0, 1'b1, 8'h00, {8'hC3, 8'h00}, 2'b01, 1, 2, 8'hC3, 1'b0, 16'h0000);
    vecs[4] = mk(16'hFFFE, 1'b0, 1'b1, 8'h00, {8'h96, 8'h00}, 2'b01, 1, 2, 8'h96, 1'b0, 16'h0000);
    vecs[5] = mk(16'h0000, 1'b1, 1'b0, 8'h81, {8'h00, 8'h00}, 2'b10, 3, 4, 8'h96, 1'b0, 16'h0000);
    vecs[6] = mk(16'h8000, 1'b0, 1'b1, 8'h00, {8'h12, 8'h34}, 2'b11, 0, 1, 8'hFF, 1'b1, CAP ? 16'h8000 : 16'h0000);
    vecs[7] = mk(16'h4000, 1'b0, 1'b1, 8'h00, {8'h12, 8'h34}, 2'b11, 0, 1, 8'hFF, 1'b1, CAP ? 16'h8000 : 16'h0000);
    vecs[8] = mk(16'hFFFF, 1'b1, 1'b0, 8'h44, {8'h12, 8'h34}, 2'b11, 0, 1, 8'hFF, 1'b1, CAP ? 16'h8000 : 16'h0000);
    vecs[9] = mk(16'h0010, 1'b1, 1'b0, 8'h5A, {8'h12, 8'h34}, 2'b10, 3, 4, 8'hFF, 1'b1, CAP ? 16'h8000 : 16'h0000);

    // Reset values while reset is held.
    @(negedge clk);
    chk("rst tgt_nsel", tgt_nsel, 2'b11);
    chk("rst tgt_nread", tgt_nread, 1'b1);
    chk("rst tgt_nwrite", tgt_nwrite, 1'b1);
    chk("rst db_ready", db_ready, 1'b0);
    chk("rst db_rdata", db_rdata, 8'hFF);
    chk("rst tgt_address", tgt_address, 16'h0000);
    chk("rst bus_error", bus_error, 1'b0);
    chk("rst err_address", err_address, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i], i);
    end

    // Abort: strobe released after one ACCESS cycle.
    do_reset();
    tgt_rdata  = {8'h00, 8'h42};
    db_address = 16'h0010;
    db_nread   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort nsel_active", tgt_nsel, 2'b10);
    db_nread = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort nsel_released", tgt_nsel, 2'b11);
    rdy_cnt = (db_ready === 1'b1) ? 1 : 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (db_ready !== 1'b0) rdy_cnt++;
    end
    chk("abort ready_cycles", rdy_cnt, 0);
    chk("abort db_rdata", db_rdata, 8'hFF);
    apply(mk(16'h0123, 1'b0, 1'b1, 8'h00, {8'h5A, 8'hA5}, 2'b10, 3, 4, 8'hA5, 1'b0, 16'h0000), 20);

    // Both strobes low, then a second error keeps the first address.
    do_reset();
    db_address = 16'h0000;
    db_nread   = 1'b0;
    db_nwrite  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("both nsel", tgt_nsel, 2'b11);
    chk("both bus_error", bus_error, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("both ready", db_ready, 1'b1);
    chk("both db_rdata", db_rdata, 8'hFF);
    chk("both err_address", err_address, 16'h0000);
    db_nread  = 1'b1;
    db_nwrite = 1'b1;
    @(posedge clk);
    @(negedge clk);
    apply(mk(16'h9000, 1'b0, 1'b1, 8'h00, 16'h0000, 2'b11, 0, 1, 8'hFF, 1'b1, 16'h0000), 21);

    // Asynchronous reset in the middle of a region 0 wait.
    apply(mk(16'hFF80, 1'b0, 1'b1, 8'h00, {8'hC3, 8'h00}, 2'b01, 1, 2, 8'hC3, 1'b1, 16'h0000), 22);
    tgt_rdata  = {8'h00, 8'hE7};
    db_address = 16'h0123;
    db_nread   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid nsel_before", tgt_nsel, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid nsel", tgt_nsel, 2'b11);
    chk("rstmid ready", db_ready, 1'b0);
    chk("rstmid db_rdata", db_rdata, 8'hFF);
    chk("rstmid bus_error", bus_error, 1'b0);
    db_nread = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply(mk(16'hFF80, 1'b0, 1'b1, 8'h00, {8'hC3, 8'h00}, 2'b01, 1, 2, 8'hC3, 1'b0, 16'h0000), 23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
